// File: rtl/value_entry_pkg.sv
// Shared widths, result limits and FSM state encoding for the value entry block.
package value_entry_pkg;

  localparam int VALUE_W = 16;
  localparam int ACC_W   = 17;

  localparam logic signed [VALUE_W-1:0] VALUE_MAX = {1'b0, {(VALUE_W-1){1'b1}}};
  localparam logic signed [VALUE_W-1:0] VALUE_MIN = {1'b1, {(VALUE_W-1){1'b0}}};

  // Largest magnitudes representable for each sign, in accumulator width
  localparam logic [ACC_W-1:0] ACC_POS_LIM = {{(ACC_W-VALUE_W+1){1'b0}}, {(VALUE_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_NEG_LIM = ACC_POS_LIM + 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/value_entry_bcd2bin_seq.sv
// Sequential BCD-to-binary accumulator (acc = acc*10 + digit) with signed saturation.
module bcd2bin_seq
  import value_entry_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clr,
  input  logic                      i_step,
  input  logic [3:0]                i_digit,
  input  logic                      i_neg,
  output logic signed [VALUE_W-1:0] o_value,
  output logic                      o_ovf
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_mul10;
  logic [ACC_W-1:0] w_negacc;

  assign w_mul10  = (r_acc << 3) + (r_acc << 1) + ACC_W'(i_digit);
  assign w_negacc = '0 - r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_acc <= '0;
    else if (i_clr)  r_acc <= '0;
    else if (i_step) r_acc <= w_mul10;
  end

  // Negative zero falls through to the plain negate path and yields +0
  always_comb begin
    o_value = '0;
    o_ovf   = 1'b0;
    if (i_neg) begin
      if (r_acc > ACC_NEG_LIM) begin
        o_value = VALUE_MIN;
        o_ovf   = 1'b1;
      end else begin
        o_value = w_negacc[VALUE_W-1:0];
      end
    end else begin
      if (r_acc > ACC_POS_LIM) begin
        o_value = VALUE_MAX;
        o_ovf   = 1'b1;
      end else begin
        o_value = r_acc[VALUE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/value_entry.sv
// Keypad decimal value entry: collects BCD digits and sign, converts to signed binary.
// Optional ENTRY_ECHO_EN adds echo_bcd/echo_neg outputs for the display path.
module value_entry
  import value_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                digit_in,
  input  logic                      digit_valid,
  input  logic                      neg_toggle,
  input  logic                      backspace,
  input  logic                      clear,
  input  logic                      enter,
  output logic                      busy,
  output logic [2:0]                digit_count,
  output logic signed [VALUE_W-1:0] value,
  output logic                      value_valid,
  output logic                      overflow
`ifdef ENTRY_ECHO_EN
  ,
  output logic [MAX_DIGITS*4-1:0]   echo_bcd,
  output logic                      echo_neg
`endif
);

  localparam int DW = MAX_DIGITS * 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_e r_state, w_next;

  logic [DW-1:0]             r_digits;
  logic [DW-1:0]             r_conv;
  logic [2:0]                r_ndig;
  logic                      r_neg;
  logic [CW-1:0]             r_cnt;
  logic signed [VALUE_W-1:0] r_value;
  logic                      r_ovf;
  logic                      r_vv;

  logic w_do_clr, w_do_enter, w_do_bksp, w_do_digit, w_do_neg;
  logic w_step, w_finish, w_busy;
  logic signed [VALUE_W-1:0] w_sat_val;
  logic                      w_sat_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_do_digit) w_next = ST_ENTRY;
      ST_ENTRY: begin
        if (w_do_clr)                          w_next = ST_IDLE;
        else if (w_do_enter)                   w_next = ST_CONVERT;
        else if (w_do_bksp && r_ndig == 3'd1)  w_next = ST_IDLE;
      end
      ST_CONVERT: begin
        if (w_do_clr)      w_next = ST_IDLE;
        else if (w_finish) w_next = ST_DONE;
      end
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Only the highest-priority asserted strobe is considered; if it is not
  // legal in the current state it is dropped rather than passing to a lower one.
  always_comb begin
    w_do_clr   = 1'b0;
    w_do_enter = 1'b0;
    w_do_bksp  = 1'b0;
    w_do_digit = 1'b0;
    w_do_neg   = 1'b0;
    w_step     = 1'b0;
    w_finish   = 1'b0;
    w_busy     = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_ENTRY: begin
        if (clear)            w_do_clr   = 1'b1;
        else if (enter)       w_do_enter = (r_state == ST_ENTRY);
        else if (backspace)   w_do_bksp  = (r_state == ST_ENTRY);
        else if (digit_valid) w_do_digit = (digit_in <= 4'd9) && (r_ndig < 3'(MAX_DIGITS));
        else if (neg_toggle)  w_do_neg   = 1'b1;
      end
      ST_CONVERT: begin
        w_busy   = 1'b1;
        w_do_clr = clear;
        w_step   = !clear && (r_cnt <  CW'(MAX_DIGITS));
        w_finish = !clear && (r_cnt == CW'(MAX_DIGITS));
      end
      ST_DONE: w_busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_conv   <= '0;
      r_ndig   <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_value  <= '0;
      r_ovf    <= 1'b0;
      r_vv     <= 1'b0;
    end else begin
      r_vv <= w_finish;
      if (w_finish) begin
        r_value <= w_sat_val;
        r_ovf   <= w_sat_ovf;
      end

      if (w_do_clr || r_state == ST_DONE) begin
        r_digits <= '0;
        r_ndig   <= '0;
        r_neg    <= 1'b0;
      end else if (w_do_bksp) begin
        r_digits <= r_digits >> 4;
        r_ndig   <= r_ndig - 3'd1;
      end else if (w_do_digit) begin
        r_digits <= {r_digits[DW-5:0], digit_in};
        r_ndig   <= r_ndig + 3'd1;
      end else if (w_do_neg) begin
        r_neg    <= ~r_neg;
      end

      // Separate conversion copy keeps the held digits intact for echo
      if (w_do_enter) begin
        r_conv <= r_digits;
        r_cnt  <= '0;
      end else if (w_step) begin
        r_conv <= r_conv << 4;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  bcd2bin_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_do_enter | w_do_clr),
    .i_step  (w_step),
    .i_digit (r_conv[DW-1 -: 4]),
    .i_neg   (r_neg),
    .o_value (w_sat_val),
    .o_ovf   (w_sat_ovf)
  );

  assign busy        = w_busy;
  assign digit_count = r_ndig;
  assign value       = r_value;
  assign value_valid = r_vv;
  assign overflow    = r_ovf;

`ifdef ENTRY_ECHO_EN
  assign echo_bcd = r_digits;
  assign echo_neg = r_neg;
`endif

endmodule

// File: tb/tb_value_entry.sv
// Directed-vector bench for value_entry: digit entry, editing, conversion, saturation, abort, reset.
module tb_value_entry;
  import value_entry_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [3:0]                digit_in = '0;
  logic                      digit_valid = 1'b0;
  logic                      neg_toggle = 1'b0;
  logic                      backspace = 1'b0;
  logic                      clear = 1'b0;
  logic                      enter = 1'b0;
  logic                      busy;
  logic [2:0]                digit_count;
  logic signed [VALUE_W-1:0] value;
  logic                      value_valid;
  logic                      overflow;
`ifdef ENTRY_ECHO_EN
  logic [19:0]               echo_bcd;
  logic                      echo_neg;
`endif

  int n_vec = 0;
  int n_err = 0;

  value_entry #(.MAX_DIGITS(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .neg_toggle  (neg_toggle),
    .backspace   (backspace),
    .clear       (clear),
    .enter       (enter),
    .busy        (busy),
    .digit_count (digit_count),
    .value       (value),
    .value_valid (value_valid),
    .overflow    (overflow)
`ifdef ENTRY_ECHO_EN
    ,
    .echo_bcd    (echo_bcd),
    .echo_neg    (echo_neg)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit_in = d; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic press_neg();
    neg_toggle = 1'b1; tick(); neg_toggle = 1'b0;
  endtask

  task automatic press_bksp();
    backspace = 1'b1; tick(); backspace = 1'b0;
  endtask

  // Enter at edge T, expect value_valid exactly after edge T+6 with the given result
  task automatic run_enter(input string tag, input int exp_val, input int exp_ovf);
    int n;
    enter = 1'b1; tick(); enter = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    n = 0;
    while (n < 20) begin
      tick(); n++;
      if (value_valid) break;
    end
    chk({tag, "_latency"}, n, 6);
    chk({tag, "_value"}, int'(value), exp_val);
    chk({tag, "_ovf"}, int'(overflow), exp_ovf);
    tick();
    chk({tag, "_idle"}, int'({busy, value_valid, digit_count}), 0);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (value_valid) pulses++;
    end
  endtask

  initial begin
    int p;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_value", int'(value), 0);
    chk("rst_flags", int'({busy, value_valid, overflow}), 0);
    chk("rst_count", int'(digit_count), 0);
    rst_n = 1'b1;
    tick();

    key(4'd1); key(4'd2); key(4'd3);
    chk("cnt_123", int'(digit_count), 3);
    run_enter("v123", 123, 0);

    press_neg(); key(4'd3); key(4'd2); key(4'd7); key(4'd6); key(4'd8);
    run_enter("neg32768", -32768, 0);

    press_neg(); key(4'd3); key(4'd2); key(4'd7); key(4'd6); key(4'd9);
    run_enter("neg32769", -32768, 1);

    for (int i = 0; i < 5; i++) key(4'd9);
    key(4'd5);
    chk("cnt_sixth", int'(digit_count), 5);
    run_enter("pos99999", 32767, 1);

    press_neg(); key(4'd0);
    run_enter("negzero", 0, 0);

    press_neg(); key(4'd1); key(4'd2);
    run_enter("neg12", -12, 0);

    key(4'd4); key(4'd5); press_bksp();
    chk("cnt_bksp", int'(digit_count), 1);
    key(4'd7); key(4'd12);
    chk("cnt_badkey", int'(digit_count), 2);
    run_enter("v47", 47, 0);

    // Backspace to empty, then enter in IDLE must do nothing
    key(4'd6); press_bksp(); press_bksp();
    chk("cnt_empty", int'(digit_count), 0);
    enter = 1'b1; tick(); enter = 1'b0;
    chk("idle_enter_busy", int'(busy), 0);
    count_pulses(8, p);
    chk("idle_enter_pulses", p, 0);

    // clear outranks a simultaneous digit
    digit_in = 4'd3; digit_valid = 1'b1; clear = 1'b1;
    tick();
    digit_valid = 1'b0; clear = 1'b0;
    chk("cnt_clr_digit", int'(digit_count), 0);

    // Abort conversion: clear sampled at T+3
    key(4'd8); key(4'd8);
    enter = 1'b1; tick(); enter = 1'b0;
    tick(); tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("abort_busy", int'(busy), 0);
    count_pulses(10, p);
    chk("abort_pulses", p, 0);
    chk("abort_value", int'(value), 47);

    // Reset mid-conversion
    key(4'd5); key(4'd5);
    enter = 1'b1; tick(); enter = 1'b0;
    tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mrst_value", int'(value), 0);
    chk("mrst_flags", int'({busy, value_valid, overflow, digit_count}), 0);
    count_pulses(10, p);
    chk("mrst_pulses", p, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/value_entry.md
VALUE_ENTRY -- requirements
Module: value_entry

Interface
REQ-001 SHALL have parameter: MAX_DIGITS, 5, maximum decimal digits accepted per entry.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: digit_in  input  4  BCD digit key code.
REQ-005 SHALL have port: digit_valid  input  1  single-cycle strobe qualifying digit_in.
REQ-006 SHALL have port: neg_toggle  input  1  strobe that inverts the pending sign.
REQ-007 SHALL have port: backspace  input  1  strobe that removes the last digit.
REQ-008 SHALL have port: clear  input  1  strobe that discards the entry, or aborts a conversion.
REQ-009 SHALL have port: enter  input  1  strobe that commits the entry for conversion.
REQ-010 SHALL have port: busy  output  1  high in CONVERT and DONE.
REQ-011 SHALL have port: digit_count  output  3  number of digits held, 0..MAX_DIGITS.
REQ-012 SHALL have port: value  output  VALUE_W  signed two's-complement result, held until next result.
REQ-013 SHALL have port: value_valid  output  1  one-cycle pulse when value updates.
REQ-014 SHALL have port: overflow  output  1  registered with value; high if the result saturated.

Function
REQ-015 SHALL implement FSM states IDLE (0 digits), ENTRY (1..MAX_DIGITS digits), CONVERT, DONE.
REQ-016 SHALL apply strobe priority in IDLE/ENTRY: clear > enter > backspace > digit_valid > neg_toggle; only the highest asserted strobe acts each cycle.
REQ-017 SHALL accept a digit only if digit_in <= 9 and digit_count < MAX_DIGITS; otherwise ignore it silently.
REQ-018 SHALL append an accepted digit as least significant, increment digit_count, and move IDLE->ENTRY.
REQ-019 SHALL decrement digit_count on backspace in ENTRY, dropping the least significant digit; ENTRY->IDLE at 0; backspace in IDLE is ignored.
REQ-020 SHALL toggle the sign flag on neg_toggle in IDLE or ENTRY.
REQ-021 SHALL ignore enter in IDLE; enter in ENTRY at cycle T moves to CONVERT.
REQ-022 SHALL convert in CONVERT one digit per cycle, most significant first, acc = acc*10 + digit, with a 17-bit accumulator, for exactly MAX_DIGITS cycles; unused leading positions are zero.
REQ-023 SHALL reach DONE at T+MAX_DIGITS+1 (T+6 by default), updating value/overflow and pulsing value_valid that cycle; DONE->IDLE next cycle with digits and sign cleared.
REQ-024 SHALL saturate: positive magnitude >32767 gives 32767; negative magnitude >32768 gives -32768; overflow=1 in both cases, else 0.
REQ-025 SHALL output +0 with overflow=0 for a negative zero entry.
REQ-026 SHALL ignore all strobes except clear while busy; clear in CONVERT returns to IDLE next cycle, with no value_valid and value/overflow unchanged.

Reset
REQ-027 SHALL, with rst_n low at a clk edge, enter IDLE and clear digits, sign, accumulator, value=0, value_valid=0, overflow=0, busy=0, digit_count=0.
REQ-028 SHALL give rst_n priority over every strobe, including mid-CONVERT, with no value_valid generated.

Configuration
REQ-029 SHALL, when ENTRY_ECHO_EN is defined, add outputs echo_bcd (MAX_DIGITS x 4) and echo_neg, giving the held digits right-aligned with leading positions zero and the sign flag, for driving the display path; both are 0 at reset.
REQ-030 SHALL, without ENTRY_ECHO_EN, omit those ports and their logic entirely.

Structure
REQ-031 SHALL take VALUE_W (16) and the FSM state enum from the shared specs package; VALUE_MAX/VALUE_MIN constants SHALL live there too.
REQ-032 SHALL place the multiply-by-10 accumulate step and saturation in one sub-module, bcd2bin_seq; all other logic is in value_entry.

Verification
REQ-033 SHALL cover: digits 1,2,3, enter at T -> value_valid at T+6, value=123, overflow=0.
REQ-034 SHALL cover: neg_toggle, digits 3,2,7,6,8, enter -> value=-32768, overflow=0; repeat with 3,2,7,6,9 -> value=-32768, overflow=1.
REQ-035 SHALL cover: digits 9,9,9,9,9, then a sixth digit 5 (ignored, digit_count stays 5), enter -> value=32767, overflow=1.
REQ-036 SHALL cover: digits 4,5, backspace, digit 7, digit_in=12 (ignored), enter -> value=47; enter in IDLE produces no pulse.
REQ-037 SHALL cover: digit_valid and clear in the same cycle -> digit_count=0; clear at T+3 of CONVERT -> no value_valid, prior value kept.
REQ-038 SHALL cover: rst_n low mid-CONVERT -> all outputs 0 next cycle, IDLE, no value_valid.
